// File: rtl/e3_mult9_seq.sv
// Serial excess-3 multiply-by-nine: consumes operand digits LSD first and
// streams the product digits back LSD first, with a final carry digit.
module e3_mult9_seq #(
    parameter int MAX_DIGITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(MAX_DIGITS - 1);

    state_t     state_q, state_d;
    logic [3:0] carry_q, carry_d;
    logic [3:0] count_q, count_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic [3:0] out_digit_q, out_digit_d;
    logic       err_q, err_d;

    logic       in_fire;
    logic       out_fire;
    logic       digit_ok;
    logic [3:0] digit_val;
    logic [6:0] t_sum;
    logic [3:0] carry_new;
    logic [3:0] sum_digit;

    assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign digit_ok  = (in_digit >= 4'd3) && (in_digit <= 4'd12);
    assign digit_val = in_digit - 4'd3;
    assign t_sum     = {3'b000, digit_val} * 7'd9 + {3'b000, carry_q};

    // Divide by ten via threshold count; t_sum never exceeds 89.
    always_comb begin
        carry_new = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            if (t_sum >= 7'(10 * k)) begin
                carry_new = carry_new + 4'd1;
            end
        end
        // Remainder is below 10, so 4-bit modular arithmetic is exact.
        sum_digit = t_sum[3:0] - carry_new * 4'd10 + 4'd3;
    end

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_digit_d = out_digit_q;
        err_d       = err_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    carry_d = 4'd0;
                    count_d = 4'd0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (in_fire) begin
                    if (!digit_ok) begin
                        state_d     = S_ERR;
                        err_d       = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        out_digit_d = sum_digit;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        carry_d     = carry_new;
                        count_d     = count_q + 4'd1;
                        if (in_last) begin
                            state_d = S_FLUSH;
                        end else if (count_q == LAST_IDX) begin
                            state_d     = S_ERR;
                            err_d       = 1'b1;
                            out_valid_d = 1'b0;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (out_valid_q && out_last_q) begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end else if (!out_valid_q || out_ready) begin
                    out_digit_d = carry_q + 4'd3;
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                end
            end
            S_ERR: begin
                out_valid_d = 1'b0;
                if (start) begin
                    carry_d = 4'd0;
                    count_d = 4'd0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            carry_q     <= 4'd0;
            count_q     <= 4'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_digit_q <= 4'b0011;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_digit_q <= out_digit_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_digit = out_digit_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_e3_mult9_seq.sv
// Scoreboard bench for e3_mult9_seq: decimal reference model feeds an
// expectation queue that a free-running output monitor drains.
module tb_e3_mult9_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_digit = 4'd0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       err;

    int tests = 0;
    int fails = 0;

    logic [4:0] exp_q[$];
    bit         rdy_random = 1'b0;
    bit         rdy_force = 1'b1;
    bit         gaps = 1'b0;

    e3_mult9_seq #(.MAX_DIGITS(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_digit(in_digit), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_digit(out_digit),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always begin
        @(posedge clk);
        #1;
        out_ready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Output monitor: scoreboard pop, hold stability and backpressure.
    bit         hold_q = 1'b0;
    logic [3:0] hold_digit;
    logic       hold_last;
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_q) begin
                tests++;
                if (out_valid !== 1'b1 || out_digit !== hold_digit || out_last !== hold_last) begin
                    fails++;
                    $display("FAIL hold_stable: got v=%b d=%b l=%b expected v=1 d=%b l=%b",
                             out_valid, out_digit, out_last, hold_digit, hold_last);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got d=%b l=%b expected none", out_digit, out_last);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    if ({out_last, out_digit} !== e) begin
                        fails++;
                        $display("FAIL out_digit: got d=%b l=%b expected d=%b l=%b",
                                 out_digit, out_last, e[3:0], e[4]);
                    end
                end
            end
        end
        hold_q     = !rst && out_valid === 1'b1 && out_ready === 1'b0;
        hold_digit = out_digit;
        hold_last  = out_last;
    end

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] dg, input logic last);
        int n = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_digit = dg;
        in_last  = last;
        do begin
            @(negedge clk);
            n++;
        end while (in_ready !== 1'b1 && n < 300);
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_digit = 4'($urandom_range(0, 15));
    endtask

    // Reference: product = 9 * operand, emitted as n+1 decimal digits.
    task automatic push_expected(input int dig[16], input int n, input int count);
        longint val = 0;
        longint pw = 1;
        longint prod;
        for (int i = 0; i < n; i++) begin
            val += dig[i] * pw;
            pw *= 10;
        end
        prod = 9 * val;
        for (int i = 0; i < count; i++) begin
            exp_q.push_back({(i == n), 4'(prod % 10 + 3)});
            prod /= 10;
        end
    endtask

    task automatic send_operand(input int dig[16], input int n);
        push_expected(dig, n, n + 1);
        start_pulse();
        for (int i = 0; i < n; i++) begin
            send_digit(4'(dig[i] + 3), i == n - 1);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drain"}, exp_q.size(), 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_err"}, err, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_err_state(input string nm);
        @(negedge clk);
        check({nm, "_err"}, err, 1);
        check({nm, "_busy"}, busy, 1);
        check({nm, "_in_ready"}, in_ready, 0);
        check({nm, "_out_valid"}, out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int dig[16];
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_digit", out_digit, 4'b0011);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        check("reset_in_ready", in_ready, 0);
        @(posedge clk); #1;

        // Single digit 5 -> 45.
        dig[0] = 5;
        send_operand(dig, 1);
        wait_idle("op_5");

        // 12 -> 108, back-to-back digits.
        dig[0] = 2; dig[1] = 1;
        send_operand(dig, 2);
        wait_idle("op_12");

        // 99 -> 891 with a three-cycle consumer stall.
        rdy_force = 1'b0;
        dig[0] = 9; dig[1] = 9;
        fork
            send_operand(dig, 2);
        join_none
        begin
            int w = 0;
            while (out_valid !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            check("stall_out_valid_seen", out_valid, 1);
            repeat (3) @(negedge clk);
            check("stall_in_ready_low", in_ready, 0);
            rdy_force = 1'b1;
        end
        wait fork;
        wait_idle("op_99");

        // Invalid digits: error, no output, recovery on start.
        for (int r = 0; r < 3; r++) begin
            int v;
            v = $urandom_range(0, 5);
            start_pulse();
            send_digit(4'((v < 3) ? v : v + 10), 1'($urandom_range(0, 1)));
            check_err_state("bad_digit");
            repeat (2) @(posedge clk);
            #1;
            check("bad_digit_sticky", err, 1);
            start_pulse();
            @(negedge clk);
            check("bad_digit_start_clears", err, 0);
            @(posedge clk); #1;
            dig[0] = r + 3; dig[1] = 7 - r;
            push_expected(dig, 2, 3);
            for (int i = 0; i < 2; i++) send_digit(4'(dig[i] + 3), i == 1);
            wait_idle("bad_digit_recover");
        end

        // Eight digits without last: first seven products, then error.
        for (int i = 0; i < 8; i++) dig[i] = $urandom_range(0, 9);
        push_expected(dig, 8, 7);
        start_pulse();
        for (int i = 0; i < 8; i++) send_digit(4'(dig[i] + 3), 1'b0);
        check_err_state("max_digits");
        check("max_digits_drain", exp_q.size(), 0);

        // Reset mid-operand with an output pending.
        rdy_force = 1'b0;
        start_pulse();
        send_digit(4'd7, 1'b0);
        @(negedge clk);
        check("pre_rst_out_valid", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_digit", out_digit, 4'b0011);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_err", err, 0);
        rdy_force = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_output", out_valid, 0);
        @(posedge clk); #1;
        dig[0] = 0;
        send_operand(dig, 1);
        wait_idle("op_zero");

        // Randomised operands with backpressure and input gaps.
        rdy_random = 1'b1;
        gaps = 1'b1;
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) dig[i] = $urandom_range(0, 9);
            send_operand(dig, n);
            wait_idle("rand_op");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
